// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute sequencer for the 4-bit core.
// Fetches instruction bytes over a req/ack ROM handshake, detects 2-byte
// commands, drives the external combinational ALU and commits results to
// acc, cy, pc or the index register file.
// Optional macro ACC_GROUP_EN: enables F-group accumulator ops (CLB, CLC, IAC, CMC, STC).
// All outputs are registered; ALU and register-file controls are set up on
// the transition into EXEC so they are stable for the whole EXEC cycle.
module alu_sequencer #(
    localparam int unsigned AW = 12,
    localparam int unsigned DW = 4,
    localparam int unsigned BW = 8,
    parameter logic [AW-1:0] PC_RESET = 12'h000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic          romReq,
    output logic [AW-1:0] romAddr,
    input  logic          romAck,
    input  logic [BW-1:0] romData,
    output logic [DW-1:0] regAddr,
    input  logic [DW-1:0] regRdata,
    output logic          regWe,
    output logic [DW-1:0] regWdata,
    output logic [DW-1:0] aluOp,
    output logic [DW-1:0] aluAccIn,
    output logic [DW-1:0] aluOpa,
    output logic          aluCarryIn,
    input  logic [DW-1:0] aluResult,
    input  logic          aluCarry,
    output logic [DW-1:0] acc,
    output logic          cy,
    output logic [AW-1:0] pc,
    output logic          instrDone
);

    localparam logic [DW-1:0] ALU_NOP = 4'h0;
    localparam logic [DW-1:0] ALU_ADD = 4'h8;
    localparam logic [DW-1:0] ALU_SUB = 4'h9;
    localparam logic [DW-1:0] ALU_LDM = 4'hD;

    localparam logic [DW-1:0] OPR_INC = 4'h6;
    localparam logic [DW-1:0] OPR_JUN = 4'h4;
    localparam logic [DW-1:0] OPR_ADD = 4'h8;
    localparam logic [DW-1:0] OPR_SUB = 4'h9;
    localparam logic [DW-1:0] OPR_LD  = 4'hA;
    localparam logic [DW-1:0] OPR_XCH = 4'hB;
    localparam logic [DW-1:0] OPR_LDM = 4'hD;
`ifdef ACC_GROUP_EN
    localparam logic [DW-1:0] OPR_FGRP = 4'hF;
    localparam logic [DW-1:0] F_CLB    = 4'h0;
    localparam logic [DW-1:0] F_CLC    = 4'h1;
    localparam logic [DW-1:0] F_IAC    = 4'h2;
    localparam logic [DW-1:0] F_CMC    = 4'h3;
    localparam logic [DW-1:0] F_STC    = 4'hA;
`endif

    typedef enum logic [1:0] {
        S_FETCH1 = 2'd0,
        S_DECODE = 2'd1,
        S_FETCH2 = 2'd2,
        S_EXEC   = 2'd3
    } state_t;

    state_t        r_state,        w_state;
    logic [BW-1:0] r_ir,           w_ir;
    logic [BW-1:0] r_ir2,          w_ir2;
    logic [DW-1:0] r_acc,          w_acc;
    logic          r_cy,           w_cy;
    logic [AW-1:0] r_pc,           w_pc;
    logic          r_rom_req,      w_rom_req;
    logic [DW-1:0] r_reg_addr,     w_reg_addr;
    logic          r_reg_we,       w_reg_we;
    logic [DW-1:0] r_reg_wdata,    w_reg_wdata;
    logic [DW-1:0] r_alu_op,       w_alu_op;
    logic [DW-1:0] r_alu_acc_in,   w_alu_acc_in;
    logic [DW-1:0] r_alu_opa,      w_alu_opa;
    logic          r_alu_carry_in, w_alu_carry_in;
    logic          r_instr_done,   w_instr_done;

    logic [DW-1:0] w_opr;
    logic [DW-1:0] w_opa;
    logic          w_ack;
    logic          w_two_byte;
    logic          w_setup;

    assign w_opr = r_ir[7:4];
    assign w_opa = r_ir[3:0];
    // Only an ack that answers an outstanding request is honoured.
    assign w_ack = romAck & r_rom_req;

    // Length decode: JCN, JUN, JMS, ISZ and FIM (OPA[0]=0) carry a second byte.
    always_comb begin
        w_two_byte = 1'b0;
        case (w_opr)
            4'h1, 4'h4, 4'h5, 4'h7: w_two_byte = 1'b1;
            4'h2:                   w_two_byte = ~w_opa[0];
            default:                w_two_byte = 1'b0;
        endcase
    end

    // Next-state, datapath commit and registered-output lookahead.
    always_comb begin
        w_state        = r_state;
        w_ir           = r_ir;
        w_ir2          = r_ir2;
        w_acc          = r_acc;
        w_cy           = r_cy;
        w_pc           = r_pc;
        w_rom_req      = 1'b0;
        w_reg_addr     = r_reg_addr;
        w_reg_we       = 1'b0;
        w_reg_wdata    = r_reg_wdata;
        w_alu_op       = ALU_NOP;
        w_alu_acc_in   = r_acc;
        w_alu_opa      = w_opa;
        w_alu_carry_in = r_cy;
        w_instr_done   = 1'b0;
        w_setup        = 1'b0;

        case (r_state)
            S_FETCH1: begin
                w_rom_req = run;
                if (w_ack) begin
                    w_ir       = romData;
                    w_reg_addr = romData[3:0];
                    w_pc       = r_pc + AW'(1);
                    w_rom_req  = 1'b0;
                    w_state    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_two_byte) begin
                    w_rom_req = 1'b1;
                    w_state   = S_FETCH2;
                end else begin
                    w_setup = 1'b1;
                    w_state = S_EXEC;
                end
            end
            S_FETCH2: begin
                w_rom_req = 1'b1;
                if (w_ack) begin
                    w_ir2     = romData;
                    w_pc      = r_pc + AW'(1);
                    w_rom_req = 1'b0;
                    w_setup   = 1'b1;
                    w_state   = S_EXEC;
                end
            end
            S_EXEC: begin
                w_rom_req = run;
                w_state   = S_FETCH1;
                case (w_opr)
                    OPR_ADD, OPR_SUB: begin
                        w_acc = aluResult;
                        w_cy  = aluCarry;
                    end
                    OPR_LDM:         w_acc = aluResult;
                    OPR_LD, OPR_XCH: w_acc = regRdata;
                    OPR_JUN:         w_pc  = {w_opa, r_ir2};
`ifdef ACC_GROUP_EN
                    OPR_FGRP: begin
                        case (w_opa)
                            F_CLB: begin
                                w_acc = '0;
                                w_cy  = 1'b0;
                            end
                            F_CLC: w_cy = 1'b0;
                            F_IAC: begin
                                w_acc = aluResult;
                                w_cy  = aluCarry;
                            end
                            F_CMC: w_cy = ~r_cy;
                            F_STC: w_cy = 1'b1;
                            default: ;
                        endcase
                    end
`endif
                    default: ;
                endcase
            end
            default: w_state = S_FETCH1;
        endcase

        // Set up ALU operands and register-file write for the coming EXEC cycle.
        if (w_setup) begin
            w_instr_done = 1'b1;
            case (w_opr)
                OPR_ADD: begin
                    w_alu_op  = ALU_ADD;
                    w_alu_opa = regRdata;
                end
                OPR_SUB: begin
                    w_alu_op  = ALU_SUB;
                    w_alu_opa = regRdata;
                end
                OPR_LDM: w_alu_op = ALU_LDM;
                OPR_XCH: begin
                    w_reg_we    = 1'b1;
                    w_reg_wdata = r_acc;
                end
                OPR_INC: begin
                    // Write data equals the ALU ADD result for regRdata + 1, cin = 0.
                    w_alu_op       = ALU_ADD;
                    w_alu_acc_in   = regRdata;
                    w_alu_opa      = DW'(1);
                    w_alu_carry_in = 1'b0;
                    w_reg_we       = 1'b1;
                    w_reg_wdata    = regRdata + DW'(1);
                end
`ifdef ACC_GROUP_EN
                OPR_FGRP: begin
                    if (w_opa == F_IAC) begin
                        w_alu_op       = ALU_ADD;
                        w_alu_opa      = DW'(1);
                        w_alu_carry_in = 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // State and datapath registers; reset abandons any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_FETCH1;
            r_ir           <= '0;
            r_ir2          <= '0;
            r_acc          <= '0;
            r_cy           <= 1'b0;
            r_pc           <= PC_RESET;
            r_rom_req      <= 1'b0;
            r_reg_addr     <= '0;
            r_reg_we       <= 1'b0;
            r_reg_wdata    <= '0;
            r_alu_op       <= ALU_NOP;
            r_alu_acc_in   <= '0;
            r_alu_opa      <= '0;
            r_alu_carry_in <= 1'b0;
            r_instr_done   <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_ir           <= w_ir;
            r_ir2          <= w_ir2;
            r_acc          <= w_acc;
            r_cy           <= w_cy;
            r_pc           <= w_pc;
            r_rom_req      <= w_rom_req;
            r_reg_addr     <= w_reg_addr;
            r_reg_we       <= w_reg_we;
            r_reg_wdata    <= w_reg_wdata;
            r_alu_op       <= w_alu_op;
            r_alu_acc_in   <= w_alu_acc_in;
            r_alu_opa      <= w_alu_opa;
            r_alu_carry_in <= w_alu_carry_in;
            r_instr_done   <= w_instr_done;
        end
    end

    assign romReq     = r_rom_req;
    assign romAddr    = r_pc;
    assign regAddr    = r_reg_addr;
    assign regWe      = r_reg_we;
    assign regWdata   = r_reg_wdata;
    assign aluOp      = r_alu_op;
    assign aluAccIn   = r_alu_acc_in;
    assign aluOpa     = r_alu_opa;
    assign aluCarryIn = r_alu_carry_in;
    assign acc        = r_acc;
    assign cy         = r_cy;
    assign pc         = r_pc;
    assign instrDone  = r_instr_done;

endmodule
